mem_burst_tester: RTL and testbench
===================================

MEM_BURST_TESTER -- requirements
Module: mem_burst_tester

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 27, word address width; DATA_W, default 32, data width; BURST_LEN, default 8, beats per burst (power of two, 2..64).
REQ-002 Clocking and reset SHALL be: one clock; reset is synchronous and active-high.
REQ-003 Ports, in this order:
- clk_clk  in  1  sole clock
- reset_reset  in  1  synchronous active-high reset
- cal_success  in  1  memory controller calibration done
- start  in  1  single-cycle run request
- base_addr  in  ADDR_W  first word address
- num_bursts  in  16  bursts to write then verify
- seed  in  32  LFSR seed
- busy  out  1  run in progress
- done  out  1  one-cycle completion pulse
- pass  out  1  last run had zero mismatches
- err_count  out  16  saturating mismatch count
- first_err_addr  out  ADDR_W  address of first mismatching word
- avl_address  out  ADDR_W  Avalon-MM burst start word address
- avl_burstcount  out  7  always BURST_LEN
- avl_write  out  1  write request
- avl_writedata  out  DATA_W  write beat
- avl_byteenable  out  DATA_W/8  all ones
- avl_read  out  1  read request
- avl_waitrequest  in  1  slave stall
- avl_readdata  in  DATA_W  read beat
- avl_readdatavalid  in  1  read beat valid

Function
REQ-004 States SHALL be IDLE, WR, RD_CMD, RD_DATA, DONE.
REQ-005 IDLE->WR on start=1 AND cal_success=1; start is ignored while cal_success=0 or busy=1.
REQ-006 On accepted start, the block SHALL latch base_addr, num_bursts and seed; a latched seed of 0 SHALL be replaced by 1.
REQ-007 num_bursts=0 SHALL go IDLE->DONE directly, with pass=1 and err_count=0.
REQ-008 WR: avl_write=1; a beat is accepted when avl_write=1 and avl_waitrequest=0; avl_address/avl_burstcount/avl_writedata SHALL be held stable while stalled.
REQ-009 Write data SHALL be successive LFSR states, first beat = latched seed; LFSR advances only on accepted beats.
REQ-010 After BURST_LEN accepted beats, the address SHALL advance by BURST_LEN modulo 2^ADDR_W; after num_bursts bursts, LFSR is reloaded with the seed and state goes to RD_CMD.
REQ-011 RD_CMD: avl_read=1 with current burst address until accepted (waitrequest=0), then RD_DATA; exactly one read burst outstanding at a time.
REQ-012 RD_DATA: each avl_readdatavalid beat SHALL be compared with the current LFSR value, then LFSR advances; readdatavalid outside RD_DATA is ignored.
REQ-013 A mismatch SHALL increment err_count (saturating at 0xFFFF); the first mismatch of a run records base-relative word address in first_err_addr.
REQ-014 After BURST_LEN beats: next burst RD_CMD, or DONE after the last burst.
REQ-015 DONE SHALL last one cycle: done=1, pass=(err_count==0), then IDLE.
REQ-016 busy=1 in every state except IDLE; avl_write and avl_read SHALL never be 1 together.
REQ-017 err_count, first_err_addr and pass SHALL hold until the next accepted start, which clears err_count, first_err_addr and pass.
REQ-018 A cal_success drop mid-run SHALL be ignored; the run completes.

Reset
REQ-019 reset_reset=1 at any clock edge SHALL force IDLE, abandoning any burst in flight.
REQ-020 Reset values SHALL be 0 for all outputs except avl_byteenable (all ones) and avl_burstcount (BURST_LEN).

Structure
REQ-021 Package mem_burst_tester_pkg SHALL hold the state enum, the default widths and the LFSR polynomial constant (x^32+x^22+x^2+x+1).
REQ-022 Sub-module lfsr32 SHALL provide a Galois LFSR with load, advance and value ports.

Verification
REQ-023 cal_success=0 with start pulse -> busy stays 0 and no avl_write ever asserted.
REQ-024 base=0x100, num_bursts=2, seed=0x1, zero-wait memory model -> 16 writes at 0x100/0x108, 16 reads, done pulse, pass=1, err_count=0.
REQ-025 Same run with random waitrequest (50%) -> writedata stable during stalls and identical write stream to REQ-024.
REQ-026 Model corrupts word at 0x10A -> pass=0, err_count=1, first_err_addr=0x00A.
REQ-027 base=0x7FFFFF8, num_bursts=2 -> second burst at 0x0000000.
REQ-028 reset_reset during WR beat 3 -> next cycle busy=0 and avl_write=0; new start completes normally with pass=1.

Source files
------------

// File: rtl/mem_burst_tester_pkg.sv
// Shared types and constants for the Avalon-MM burst write/verify tester.
// Holds the FSM encoding, default widths and the LFSR polynomial.
package mem_burst_tester_pkg;

  localparam int ADDR_W_DEF    = 27;
  localparam int DATA_W_DEF    = 32;
  localparam int BURST_LEN_DEF = 8;

  // x^32 + x^22 + x^2 + x + 1 in right-shifting Galois form (taps 31,21,1,0)
  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD_CMD,
    RD_DATA,
    DONE
  } state_t;

  function automatic logic [31:0] lfsr_next(input logic [31:0] v);
    return (v >> 1) ^ (v[0] ? LFSR_POLY : 32'h0);
  endfunction

endpackage

// File: rtl/mem_burst_tester_lfsr32.sv
// 32-bit Galois LFSR pattern source; load has priority over advance.
module lfsr32
  import mem_burst_tester_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        advance,
  input  logic [31:0] seed,
  output logic [31:0] value
);

  always_ff @(posedge clk) begin
    if (reset)        value <= '0;
    else if (load)    value <= seed;
    else if (advance) value <= lfsr_next(value);
  end

endmodule

// File: rtl/mem_burst_tester.sv
// Writes an LFSR pattern over num_bursts Avalon-MM bursts, then reads it back
// one burst at a time and counts mismatching words.
module mem_burst_tester
  import mem_burst_tester_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int BURST_LEN = BURST_LEN_DEF
) (
  input  logic                clk_clk,
  input  logic                reset_reset,
  input  logic                cal_success,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [15:0]         num_bursts,
  input  logic [31:0]         seed,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [15:0]         err_count,
  output logic [ADDR_W-1:0]   first_err_addr,
  output logic [ADDR_W-1:0]   avl_address,
  output logic [6:0]          avl_burstcount,
  output logic                avl_write,
  output logic [DATA_W-1:0]   avl_writedata,
  output logic [DATA_W/8-1:0] avl_byteenable,
  output logic                avl_read,
  input  logic                avl_waitrequest,
  input  logic [DATA_W-1:0]   avl_readdata,
  input  logic                avl_readdatavalid
);

  localparam int BW = $clog2(BURST_LEN);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);

  state_t            state, nstate;
  logic [ADDR_W-1:0] addr_q, base_q, first_q;
  logic [15:0]       bursts_q, burst_cnt, err_q;
  logic [BW-1:0]     beat_cnt;
  logic [31:0]       seed_q, seed_fix, lfsr_seed, lfsr_val;
  logic              err_seen, pass_q;
  logic              start_ok, wr_acc, rd_beat, beat_last, burst_last, mismatch;
  logic              lfsr_load, lfsr_adv;

  assign start_ok   = start && cal_success && (state == IDLE);
  assign wr_acc     = (state == WR) && !avl_waitrequest;
  assign rd_beat    = (state == RD_DATA) && avl_readdatavalid;
  assign beat_last  = (beat_cnt == LAST_BEAT);
  assign burst_last = (burst_cnt == bursts_q - 16'd1);
  assign mismatch   = rd_beat && (avl_readdata != DATA_W'(lfsr_val));
  assign seed_fix   = (seed == 32'd0) ? 32'd1 : seed;

  // Reload on the last write beat so the read pass replays the same stream.
  assign lfsr_load = start_ok || (wr_acc && beat_last && burst_last);
  assign lfsr_seed = start_ok ? seed_fix : seed_q;
  assign lfsr_adv  = wr_acc || rd_beat;

  lfsr32 u_lfsr (
    .clk     (clk_clk),
    .reset   (reset_reset),
    .load    (lfsr_load),
    .advance (lfsr_adv),
    .seed    (lfsr_seed),
    .value   (lfsr_val)
  );

  always_ff @(posedge clk_clk) begin
    if (reset_reset) state <= IDLE;
    else             state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      IDLE:    if (start_ok) nstate = (num_bursts == 16'd0) ? DONE : WR;
      WR:      if (wr_acc && beat_last && burst_last) nstate = RD_CMD;
      RD_CMD:  if (!avl_waitrequest) nstate = RD_DATA;
      RD_DATA: if (rd_beat && beat_last) nstate = burst_last ? DONE : RD_CMD;
      DONE:    nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_comb begin
    busy           = (state != IDLE);
    done           = (state == DONE);
    pass           = (state == DONE) ? (err_q == 16'd0) : pass_q;
    avl_write      = (state == WR);
    avl_read       = (state == RD_CMD);
    avl_address    = addr_q;
    avl_burstcount = 7'(BURST_LEN);
    avl_byteenable = '1;
    avl_writedata  = (state == WR) ? DATA_W'(lfsr_val) : '0;
    err_count      = err_q;
    first_err_addr = first_q;
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      addr_q    <= '0;
      base_q    <= '0;
      first_q   <= '0;
      bursts_q  <= '0;
      burst_cnt <= '0;
      err_q     <= '0;
      beat_cnt  <= '0;
      seed_q    <= '0;
      err_seen  <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      if (start_ok) begin
        addr_q    <= base_addr;
        base_q    <= base_addr;
        bursts_q  <= num_bursts;
        seed_q    <= seed_fix;
        burst_cnt <= '0;
        beat_cnt  <= '0;
        err_q     <= '0;
        first_q   <= '0;
        err_seen  <= 1'b0;
        pass_q    <= 1'b0;
      end
      if (wr_acc || rd_beat) begin
        beat_cnt <= beat_cnt + BW'(1);
        if (beat_last) begin
          if (burst_last) begin
            addr_q    <= base_q;
            burst_cnt <= '0;
          end else begin
            addr_q    <= addr_q + ADDR_W'(BURST_LEN);
            burst_cnt <= burst_cnt + 16'd1;
          end
        end
      end
      if (mismatch) begin
        if (err_q != 16'hFFFF) err_q <= err_q + 16'd1;
        if (!err_seen) begin
          first_q  <= addr_q + ADDR_W'(beat_cnt) - base_q;
          err_seen <= 1'b1;
        end
      end
      if (state == DONE) pass_q <= (err_q == 16'd0);
    end
  end

endmodule

// File: tb/tb_mem_burst_tester.sv
// Directed bench: Avalon-MM memory model plus a table of runs with hand-derived results.
module tb_mem_burst_tester;

  localparam int AW = 27;
  localparam int DW = 32;
  localparam int BL = 8;

  logic          clk = 1'b0;
  logic          reset_reset, cal_success, start;
  logic [AW-1:0] base_addr;
  logic [15:0]   num_bursts;
  logic [31:0]   seed;
  logic          busy, done, pass;
  logic [15:0]   err_count;
  logic [AW-1:0] first_err_addr, avl_address;
  logic [6:0]    avl_burstcount;
  logic          avl_write, avl_read;
  logic [DW-1:0] avl_writedata, avl_readdata;
  logic [3:0]    avl_byteenable;
  logic          avl_waitrequest, avl_readdatavalid;

  mem_burst_tester dut (
    .clk_clk(clk), .reset_reset(reset_reset), .cal_success(cal_success), .start(start),
    .base_addr(base_addr), .num_bursts(num_bursts), .seed(seed),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_err_addr(first_err_addr), .avl_address(avl_address),
    .avl_burstcount(avl_burstcount), .avl_write(avl_write),
    .avl_writedata(avl_writedata), .avl_byteenable(avl_byteenable),
    .avl_read(avl_read), .avl_waitrequest(avl_waitrequest),
    .avl_readdata(avl_readdata), .avl_readdatavalid(avl_readdatavalid)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // x^32+x^22+x^2+x+1, right-shift Galois: taps at bits 31,21,1,0
  function automatic logic [31:0] nxt(input logic [31:0] v);
    logic [31:0] r;
    r = v >> 1;
    if (v[0]) r = r ^ {1'b1, 9'b0, 1'b1, 19'b0, 2'b11};
    return r;
  endfunction

  typedef struct {
    logic [AW-1:0] base;
    logic [15:0]   nb;
    logic [31:0]   seed;
    bit            rnd;
    bit            corrupt_en;
    logic [AW-1:0] corrupt;
    bit            exp_pass;
    logic [15:0]   exp_err;
    logic [AW-1:0] exp_first;
    logic [AW-1:0] exp_b1;
  } vec_t;

  // memory model state
  logic [31:0]   mem [int];
  bit            rnd_mode = 0, model_clr = 0, corrupt_en = 0, any_write = 0, prev_stall = 0;
  logic [AW-1:0] corrupt_addr, waddr, raddr, ta, prev_addr;
  logic [31:0]   exp_lfsr, prev_data;
  logic [31:0]   wr_log[$], saved[$];
  logic [AW-1:0] burst_log[$];
  int            wbeat = 0, rleft = 0, rbeat = 0, rd_count = 0;

  // Every decision is made at negedge for the following posedge.
  always @(negedge clk) begin
    if (model_clr) begin
      wbeat = 0; rleft = 0; prev_stall = 0;
      avl_waitrequest = 1'b0; avl_readdatavalid = 1'b0;
    end else begin
      if (busy) chk("wr_rd_exclusive", 64'(avl_write & avl_read), 64'd0);
      if (prev_stall) begin
        chk("stall_hold_data", 64'(avl_writedata), 64'(prev_data));
        chk("stall_hold_addr", 64'(avl_address), 64'(prev_addr));
      end
      avl_readdatavalid = 1'b0;
      if (rleft > 0 && (!rnd_mode || $urandom_range(0, 1) == 1)) begin
        ta = raddr + AW'(rbeat);
        avl_readdata = mem.exists(int'(ta)) ? mem[int'(ta)] : 32'h0;
        if (corrupt_en && ta == corrupt_addr) avl_readdata = avl_readdata ^ 32'h100;
        avl_readdatavalid = 1'b1;
        rleft--; rbeat++; rd_count++;
      end
      avl_waitrequest = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b0;
      prev_stall = avl_write && avl_waitrequest;
      prev_data  = avl_writedata;
      prev_addr  = avl_address;
      if (avl_write) begin
        any_write = 1;
        if (!avl_waitrequest) begin
          if (wbeat == 0) begin
            waddr = avl_address;
            burst_log.push_back(avl_address);
          end
          ta = waddr + AW'(wbeat);
          mem[int'(ta)] = avl_writedata;
          chk("wr_data", 64'(avl_writedata), 64'(exp_lfsr));
          exp_lfsr = nxt(exp_lfsr);
          wr_log.push_back(avl_writedata);
          wbeat = (wbeat + 1) % BL;
        end
      end
      if (avl_read && !avl_waitrequest) begin
        raddr = avl_address; rleft = BL; rbeat = 0;
      end
    end
  end

  task automatic prep(input vec_t v);
    wr_log.delete(); burst_log.delete();
    rd_count = 0; any_write = 0;
    rnd_mode = v.rnd; corrupt_en = v.corrupt_en; corrupt_addr = v.corrupt;
    exp_lfsr = (v.seed == 32'd0) ? 32'd1 : v.seed;
    cal_success = 1'b1; base_addr = v.base; num_bursts = v.nb; seed = v.seed;
  endtask

  task automatic run_vec(input vec_t v);
    @(negedge clk);
    prep(v);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 4000 && !done; c++) @(negedge clk);
    chk("done_seen", 64'(done), 64'd1);
    if (done) begin
      chk("done_busy", 64'(busy), 64'd1);
      chk("pass", 64'(pass), 64'(v.exp_pass));
      chk("err_count", 64'(err_count), 64'(v.exp_err));
      chk("first_err_addr", 64'(first_err_addr), 64'(v.exp_first));
      @(negedge clk);
      chk("done_one_cycle", 64'(done), 64'd0);
      chk("idle_busy", 64'(busy), 64'd0);
      chk("pass_held", 64'(pass), 64'(v.exp_pass));
      chk("err_held", 64'(err_count), 64'(v.exp_err));
    end
    chk("wr_beats", 64'(wr_log.size()), 64'(v.nb) * BL);
    chk("rd_beats", 64'(rd_count), 64'(v.nb) * BL);
    if (v.nb >= 1 && burst_log.size() >= 1) chk("burst0_addr", 64'(burst_log[0]), 64'(v.base));
    if (v.nb >= 2 && burst_log.size() >= 2) chk("burst1_addr", 64'(burst_log[1]), 64'(v.exp_b1));
  endtask

  vec_t        vecs[6];
  logic [31:0] k1[4];
  bit          busy_seen;

  initial begin
    //           base         nb  seed          rnd cor  corrupt      pass err first       b1
    vecs[0] = '{27'h0000100,  2, 32'h1,        0, 0,   27'h0,       1,   0,  27'h0,  27'h0000108};
    vecs[1] = '{27'h0000100,  2, 32'h1,        1, 0,   27'h0,       1,   0,  27'h0,  27'h0000108};
    vecs[2] = '{27'h0000100,  2, 32'h1,        0, 1,   27'h000010A, 0,   1,  27'h00A, 27'h0000108};
    vecs[3] = '{27'h0000100,  0, 32'h1,        0, 0,   27'h0,       1,   0,  27'h0,  27'h0};
    vecs[4] = '{27'h7FFFFF8,  2, 32'hDEADBEEF, 0, 0,   27'h0,       1,   0,  27'h0,  27'h0000000};
    vecs[5] = '{27'h0002000,  1, 32'h0,        0, 0,   27'h0,       1,   0,  27'h0,  27'h0};
    k1[0] = 32'h0000_0001; k1[1] = 32'h8020_0003; k1[2] = 32'hC030_0002; k1[3] = 32'h6018_0001;

    reset_reset = 1'b1; cal_success = 1'b0; start = 1'b0;
    base_addr = '0; num_bursts = '0; seed = '0;
    avl_waitrequest = 1'b0; avl_readdatavalid = 1'b0; avl_readdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_pass", 64'(pass), 64'd0);
    chk("rst_err", 64'(err_count), 64'd0);
    chk("rst_first", 64'(first_err_addr), 64'd0);
    chk("rst_addr", 64'(avl_address), 64'd0);
    chk("rst_burstcount", 64'(avl_burstcount), 64'd8);
    chk("rst_byteenable", 64'(avl_byteenable), 64'hF);
    chk("rst_write", 64'(avl_write), 64'd0);
    chk("rst_read", 64'(avl_read), 64'd0);
    chk("rst_wdata", 64'(avl_writedata), 64'd0);
    reset_reset = 1'b0;

    // start without calibration is ignored
    @(negedge clk);
    any_write = 0; busy_seen = 0;
    base_addr = 27'h100; num_bursts = 16'd1; seed = 32'h1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 20; c++) begin
      busy_seen |= busy;
      @(negedge clk);
    end
    chk("nocal_busy", 64'(busy_seen), 64'd0);
    chk("nocal_write", 64'(any_write), 64'd0);

    for (int i = 0; i < 6; i++) begin
      run_vec(vecs[i]);
      if (i == 0) begin
        for (int j = 0; j < 4; j++)
          if (wr_log.size() > j) chk("seed1_stream", 64'(wr_log[j]), 64'(k1[j]));
        saved = wr_log;
      end
      if (i == 1) begin
        chk("stall_stream_len", 64'(wr_log.size()), 64'(saved.size()));
        for (int j = 0; j < wr_log.size() && j < saved.size(); j++)
          chk("stall_stream_same", 64'(wr_log[j]), 64'(saved[j]));
      end
      if (i == 5 && wr_log.size() > 0) chk("seed0_becomes1", 64'(wr_log[0]), 64'd1);
    end

    // reset in the middle of a write burst
    @(negedge clk);
    prep(vecs[0]);
    base_addr = 27'h300; num_bursts = 16'd2; seed = 32'h5; exp_lfsr = 32'h5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 100 && wr_log.size() < 3; c++) @(negedge clk);
    chk("rst_mid_in_wr", 64'(avl_write), 64'd1);
    reset_reset = 1'b1; model_clr = 1'b1;
    @(negedge clk);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_write", 64'(avl_write), 64'd0);
    reset_reset = 1'b0; model_clr = 1'b0;
    run_vec(vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
